// File: rtl/uart_pkg.sv
// Shared UART receive constants: byte width and the receive handshake state encoding.
package uart_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic {
    RECV = 1'b0,
    ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: synchronous write, synchronous read-before-write.
module fifo_ram #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // A read and write to the same address in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uartrx_fifo.sv
// UART receive buffer: runs the UartRx go/dr handshake and queues bytes in a circular
// FIFO that the CPU drains with a pop-on-read port of one-cycle latency.
module uartrx_fifo import uart_pkg::*; #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uartrx_dr,
  input  logic [DATA_WIDTH-1:0] uartrx_data,
  output logic                  uartrx_go,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  rx_state_t             state, state_next;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push_req, push, pop;
  logic                  zero_p1;
  logic [DATA_WIDTH-1:0] ram_q_p1;

  // Handshake: go is high while receiving, low for the single acknowledge cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= RECV;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    uartrx_go  = 1'b1;
    push_req   = 1'b0;
    case (state)
      RECV: begin
        push_req = uartrx_dr;
        if (uartrx_dr) state_next = ACK;
      end
      ACK: begin
        uartrx_go  = 1'b0;
        state_next = RECV;
      end
      default: state_next = RECV;
    endcase
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push then.
  assign pop   = rd_en && (count != '0);
  assign push  = push_req && (!full || pop);
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      zero_p1  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      // Remember whether the last read hit an empty FIFO; that read returns zero.
      if (rd_en) zero_p1 <= !pop;
    end
  end

  fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (uartrx_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (ram_q_p1)
  );

  // ---- stage p1: read data out of the array ----
  assign dout = zero_p1 ? '0 : ram_q_p1;

endmodule

// File: tb/tb_uartrx_fifo.sv
// Bench for uartrx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uartrx_fifo;

  localparam int DL    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, dr, rd_en, clr;
  logic [DW-1:0] data;
  logic          go, empty, full, overflow;
  logic [DW-1:0] dout;
  logic [DL:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ack, m_ov;
  logic [DW-1:0] m_dout;

  uartrx_fifo #(.DEPTH_LOG2(DL), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .uartrx_dr    (dr),
    .uartrx_data  (data),
    .uartrx_go    (go),
    .rd_en        (rd_en),
    .dout         (dout),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the model on the edge, check outputs 1 ns later.
  task automatic tick(input logic i_rst, input logic i_dr, input logic [DW-1:0] i_data,
                      input logic i_rd, input logic i_clr);
    bit pop_ok, push_req, accept;
    rst = i_rst; dr = i_dr; data = i_data; rd_en = i_rd; clr = i_clr;
    @(posedge clk);
    if (i_rst) begin
      q.delete();
      m_ack  = 1'b0;
      m_ov   = 1'b0;
      m_dout = '0;
    end else begin
      pop_ok   = i_rd && (q.size() > 0);
      push_req = !m_ack && i_dr;
      if (i_rd) m_dout = pop_ok ? q[0] : '0;
      accept = push_req && ((q.size() < DEPTH) || pop_ok);
      if (pop_ok) void'(q.pop_front());
      if (accept) q.push_back(i_data);
      if (push_req && !accept) m_ov = 1'b1;
      else if (i_clr)          m_ov = 1'b0;
      m_ack = push_req;
    end
    #1;
    chk("go",       32'(go),       32'(!m_ack));
    chk("count",    32'(count),    32'(q.size()));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("dout",     32'(dout),     32'(m_dout));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] b);
    tick(1'b0, 1'b1, b, 1'b0, 1'b0);
    idle();
  endtask

  task automatic pop();
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] b;
    rst = 1'b1; dr = 1'b0; data = '0; rd_en = 1'b0; clr = 1'b0;
    m_ack = 1'b0; m_ov = 1'b0; m_dout = '0;

    // Reset and a read of an empty FIFO
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_go", 32'(go), 32'd1);
    pop();
    chk("empty_rd_dout", 32'(dout), 32'd0);

    // Three bytes in, three out
    push(8'h41); push(8'h42); push(8'h43);
    chk("three_count", 32'(count), 32'd3);
    pop(); chk("pop41", 32'(dout), 32'h41);
    pop(); chk("pop42", 32'(dout), 32'h42);
    pop(); chk("pop43", 32'(dout), 32'h43);

    // Overfill: 17 pushes, last one dropped
    for (int i = 0; i < 17; i++) push(8'(i));
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) pop();
    chk("ovf_last", 32'(dout), 32'h0F);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    tick(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("simul_count", 32'(count), 32'd16);
    chk("simul_dout",  32'(dout),  32'h80);
    chk("simul_ovf",   32'(overflow), 32'd0);
    idle();
    for (int i = 0; i < 16; i++) pop();
    chk("simul_tail", 32'(dout), 32'hAA);

    // Interleaved traffic wrapping the pointers
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom));
      if ((i % 3) == 2) begin pop(); pop(); pop(); end
    end
    while (q.size() > 0) pop();

    // Reset with queued bytes
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    pop();
    chk("rst_rd", 32'(dout), 32'd0);
    push(8'h55);
    pop();
    chk("post_rst", 32'(dout), 32'h55);

    // Random traffic in phases of differing read pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        b = 8'($urandom);
        tick(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 1) == 1),
             b,
             ($urandom_range(0, 9) < (ph * 3)),
             ($urandom_range(0, 15) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
